// File: rtl/fixedpoint_pkg.sv
`default_nettype none
// ============================================================================
// fixedpoint : Q8.8 signed fixed-point type, limits and saturating add helpers
// Revision   : 1.0
// ============================================================================
package fixedpoint;

    localparam int FP_WIDTH = 16;

    typedef logic signed [FP_WIDTH-1:0] fixed_point_t;

    localparam fixed_point_t FP_MAX = 16'sh7FFF;
    localparam fixed_point_t FP_MIN = 16'sh8000;

    // True when a + b leaves the representable range (sign bits disagree).
    function automatic logic fp_add_ovf(fixed_point_t a, fixed_point_t b);
        logic signed [FP_WIDTH:0] sum;
        sum = {a[FP_WIDTH-1], a} + {b[FP_WIDTH-1], b};
        return sum[FP_WIDTH] != sum[FP_WIDTH-1];
    endfunction

    function automatic fixed_point_t fp_sat_add(fixed_point_t a, fixed_point_t b);
        logic signed [FP_WIDTH:0] sum;
        sum = {a[FP_WIDTH-1], a} + {b[FP_WIDTH-1], b};
        if (sum[FP_WIDTH] != sum[FP_WIDTH-1]) begin
            return sum[FP_WIDTH] ? FP_MIN : FP_MAX;
        end
        return sum[FP_WIDTH-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/weight_update.sv
`default_nettype none
// ============================================================================
// weight_update : register-based weight store with saturating update stage,
//                 registered read port and sequential clear
// Revision      : 1.0
// ============================================================================
module weight_update
    import fixedpoint::*;
#(
    parameter int           NUM_WEIGHTS = 16,
    parameter fixed_point_t INIT_WEIGHT = '0,
    parameter int           IDX_W       = $clog2(NUM_WEIGHTS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [IDX_W-1:0]   upd_index,
    input  fixed_point_t       weight_delta,
    input  logic               clear_req,
    output logic               clear_done,
    input  logic [IDX_W-1:0]   rd_index,
    output fixed_point_t       rd_weight,
    output logic [15:0]        update_count,
    output logic               sat_flag,
    output logic               idx_err
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WEIGHTS - 1);

    state_t             r_state;
    state_t             w_state_next;
    fixed_point_t       r_weights [NUM_WEIGHTS];
    logic               r_stg_valid;
    logic [IDX_W-1:0]   r_stg_idx;
    fixed_point_t       r_stg_delta;
    logic [IDX_W-1:0]   r_clr_cnt;

    logic               w_fire;
    logic               w_upd_in_range;
    logic               w_stg_in_range;
    logic               w_rd_in_range;
    logic               w_clr_write;
    logic               w_clr_last;
    fixed_point_t       w_cur;
    fixed_point_t       w_sum;
    logic               w_ovf;

    assign upd_ready      = (r_state == RUN);
    assign w_fire         = upd_valid && upd_ready;
    assign w_upd_in_range = (32'(upd_index) < NUM_WEIGHTS);
    assign w_stg_in_range = (32'(r_stg_idx) < NUM_WEIGHTS);
    assign w_rd_in_range  = (32'(rd_index)  < NUM_WEIGHTS);

    assign w_cur = w_stg_in_range ? r_weights[r_stg_idx] : '0;
    assign w_sum = fp_sat_add(w_cur, r_stg_delta);
    assign w_ovf = fp_add_ovf(w_cur, r_stg_delta);

    // A pending stage update always drains before the clear sweep writes,
    // so the two never target the array on the same edge.
    always_comb begin
        w_state_next = r_state;
        w_clr_write  = 1'b0;
        w_clr_last   = 1'b0;
        case (r_state)
            RUN: begin
                if (clear_req) begin
                    w_state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (!r_stg_valid) begin
                    w_clr_write = 1'b1;
                    if (r_clr_cnt == LAST_IDX) begin
                        w_clr_last   = 1'b1;
                        w_state_next = RUN;
                    end
                end
            end
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_WEIGHTS; k++) begin
                r_weights[k] <= INIT_WEIGHT;
            end
            r_stg_valid  <= 1'b0;
            r_stg_idx    <= '0;
            r_stg_delta  <= '0;
            r_clr_cnt    <= '0;
            clear_done   <= 1'b0;
            rd_weight    <= '0;
            update_count <= '0;
            sat_flag     <= 1'b0;
            idx_err      <= 1'b0;
        end else begin
            clear_done  <= w_clr_last;
            rd_weight   <= w_rd_in_range ? r_weights[rd_index] : '0;
            r_stg_valid <= w_fire;
            if (w_fire) begin
                r_stg_idx   <= upd_index;
                r_stg_delta <= weight_delta;
            end
            // Out-of-range updates are accepted and flagged, then dropped.
            if (w_fire && !w_upd_in_range) begin
                idx_err <= 1'b1;
            end
            if (r_stg_valid && w_stg_in_range) begin
                r_weights[r_stg_idx] <= w_sum;
                update_count         <= update_count + 16'd1;
                if (w_ovf) begin
                    sat_flag <= 1'b1;
                end
            end else if (w_clr_write) begin
                r_weights[r_clr_cnt] <= INIT_WEIGHT;
                r_clr_cnt            <= w_clr_last ? '0 : r_clr_cnt + IDX_W'(1);
            end
            if (w_clr_last) begin
                update_count <= '0;
                sat_flag     <= 1'b0;
                idx_err      <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_weight_update.sv
`default_nettype none
// ============================================================================
// tb_weight_update : two instances (16 and 12 weights) driven in parallel and
//                    checked every cycle against a behavioural model
// Revision         : 1.0
// ============================================================================
module tb_weight_update;
    import fixedpoint::*;

    localparam int NWS   [2] = '{16, 12};
    localparam int INITS [2] = '{0, 64};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic        clear_req = 1'b0;
    logic [3:0]  upd_index = '0;
    logic [3:0]  rd_index = '0;
    logic [15:0] weight_delta = '0;

    logic        rdy  [2];
    logic        done [2];
    logic        satf [2];
    logic        ierr [2];
    logic [15:0] rdw  [2];
    logic [15:0] ucnt [2];

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    weight_update #(.NUM_WEIGHTS(16), .INIT_WEIGHT(16'sh0000)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(rdy[0]),
        .upd_index(upd_index), .weight_delta(weight_delta), .clear_req(clear_req),
        .clear_done(done[0]), .rd_index(rd_index), .rd_weight(rdw[0]),
        .update_count(ucnt[0]), .sat_flag(satf[0]), .idx_err(ierr[0])
    );

    weight_update #(.NUM_WEIGHTS(12), .INIT_WEIGHT(16'sh0040)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(rdy[1]),
        .upd_index(upd_index), .weight_delta(weight_delta), .clear_req(clear_req),
        .clear_done(done[1]), .rd_index(rd_index), .rd_weight(rdw[1]),
        .update_count(ucnt[1]), .sat_flag(satf[1]), .idx_err(ierr[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  mw    [2][16];
    bit  pv    [2];
    int  pidx  [2];
    int  pdel  [2];
    bit  mclr  [2];
    int  ccnt  [2];
    int  mcnt  [2];
    bit  msat  [2];
    bit  merr  [2];
    bit  mdone [2];
    int  mrd   [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 16; k++) mw[i][k] = INITS[i];
                pv[i] = 0; pidx[i] = 0; pdel[i] = 0; mclr[i] = 0; ccnt[i] = 0;
                mcnt[i] = 0; msat[i] = 0; merr[i] = 0; mdone[i] = 0; mrd[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int  s;
                bit  pv_o;
                bit  clr_o;
                bit  fire;
                pv_o  = pv[i];
                clr_o = mclr[i];
                fire  = upd_valid && !clr_o;
                mrd[i]   = (int'(rd_index) < NWS[i]) ? mw[i][rd_index] : 0;
                mdone[i] = 0;
                if (pv_o) begin
                    if (pidx[i] < NWS[i]) begin
                        s = mw[i][pidx[i]] + pdel[i];
                        if (s > 32767) begin s = 32767; msat[i] = 1; end
                        else if (s < -32768) begin s = -32768; msat[i] = 1; end
                        mw[i][pidx[i]] = s;
                        mcnt[i] = (mcnt[i] + 1) % 65536;
                    end
                    pv[i] = 0;
                end else if (clr_o) begin
                    mw[i][ccnt[i]] = INITS[i];
                    ccnt[i]++;
                    if (ccnt[i] == NWS[i]) begin
                        ccnt[i] = 0; mclr[i] = 0; mdone[i] = 1;
                        mcnt[i] = 0; msat[i] = 0; merr[i] = 0;
                    end
                end
                if (!clr_o && clear_req) mclr[i] = 1;
                if (fire) begin
                    pv[i]   = 1;
                    pidx[i] = int'(upd_index);
                    pdel[i] = int'($signed(weight_delta));
                    if (int'(upd_index) >= NWS[i]) merr[i] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("inst%0d upd_ready", i),    int'(rdy[i]),  int'(!mclr[i]));
            chk($sformatf("inst%0d clear_done", i),   int'(done[i]), int'(mdone[i]));
            chk($sformatf("inst%0d rd_weight", i),    int'($signed(rdw[i])), mrd[i]);
            chk($sformatf("inst%0d update_count", i), int'(ucnt[i]), mcnt[i]);
            chk($sformatf("inst%0d sat_flag", i),     int'(satf[i]), int'(msat[i]));
            chk($sformatf("inst%0d idx_err", i),      int'(ierr[i]), int'(merr[i]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input logic [15:0] d);
        upd_valid    = 1'b1;
        upd_index    = 4'(idx);
        weight_delta = d;
        cyc();
        upd_valid    = 1'b0;
    endtask

    task automatic rd(input int idx);
        rd_index = 4'(idx);
        cyc();
    endtask

    task automatic check_all_init(input string tag);
        for (int k = 0; k < 16; k++) begin
            rd(k);
            chk($sformatf("%s w16[%0d]", tag, k), int'(rdw[0]), 0);
            chk($sformatf("%s w12[%0d]", tag, k), int'(rdw[1]), (k < 12) ? 64 : 0);
        end
    endtask

    int low16, low12, dn16, dn12, hi16;

    initial begin
        repeat (3) cyc();
        chk("reset rd_weight16", int'(rdw[0]), 0);
        chk("reset upd_ready16", int'(rdy[0]), 1);
        chk("reset count16",     int'(ucnt[0]), 0);
        chk("reset flags16",     int'({satf[0], ierr[0], done[0]}), 0);
        rst_n = 1'b1;
        cyc();
        check_all_init("reset");

        // Same-index back-to-back updates.
        send(3, 16'h0100);
        send(3, 16'hFF80);
        cyc();
        rd(3);
        chk("idx3 w16", int'(rdw[0]), 16'h0080);
        chk("idx3 w12", int'(rdw[1]), 16'h00C0);
        chk("count16 after 2", int'(ucnt[0]), 2);
        chk("count12 after 2", int'(ucnt[1]), 2);

        // Positive and negative saturation.
        send(5, 16'h7F00);
        send(5, 16'h0200);
        cyc();
        rd(5);
        chk("idx5 sat w16", int'(rdw[0]), 16'h7FFF);
        chk("idx5 sat w12", int'(rdw[1]), 16'h7FFF);
        chk("sat_flag16", int'(satf[0]), 1);
        chk("sat_flag12", int'(satf[1]), 1);
        send(6, 16'h8000);
        send(6, 16'h8000);
        cyc();
        rd(6);
        chk("idx6 neg w16", int'(rdw[0]), 16'h8000);
        chk("idx6 neg w12", int'(rdw[1]), 16'h8000);

        // Index 13: valid for 16 weights, out of range for 12.
        send(13, 16'h0100);
        cyc();
        cyc();
        chk("idx_err12", int'(ierr[1]), 1);
        chk("idx_err16", int'(ierr[0]), 0);
        chk("count12 oob", int'(ucnt[1]), 6);
        chk("count16 idx13", int'(ucnt[0]), 7);
        rd(13);
        chk("rd13 w12", int'(rdw[1]), 0);
        chk("rd13 w16", int'(rdw[0]), 16'h0100);

        // Clear requested in the same cycle as an update handshake.
        rd_index     = 4'd0;
        upd_valid    = 1'b1;
        upd_index    = 4'd0;
        weight_delta = 16'h0010;
        clear_req    = 1'b1;
        cyc();
        upd_valid = 1'b0;
        clear_req = 1'b0;
        low16 = 0; low12 = 0; dn16 = 0; dn12 = 0;
        for (int c = 0; c < 25; c++) begin
            if (!rdy[0]) low16++;
            if (!rdy[1]) low12++;
            if (done[0]) dn16++;
            if (done[1]) dn12++;
            if (c == 2) begin
                chk("landed w16[0]", int'(rdw[0]), 16'h0010);
                chk("landed w12[0]", int'(rdw[1]), 16'h0050);
            end
            cyc();
        end
        chk("ready low16", low16, 17);
        chk("ready low12", low12, 13);
        chk("done pulses16", dn16, 1);
        chk("done pulses12", dn12, 1);
        chk("cleared count16", int'(ucnt[0]), 0);
        chk("cleared flags12", int'({satf[1], ierr[1]}), 0);
        check_all_init("clear");

        // Randomised traffic, including occasional clears.
        for (int n = 0; n < 3000; n++) begin
            upd_valid = ($urandom_range(0, 9) < 7);
            upd_index = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) weight_delta = 16'($urandom);
            else weight_delta = 16'($urandom_range(0, 1023) - 512);
            clear_req = ($urandom_range(0, 63) == 0);
            rd_index  = 4'($urandom_range(0, 15));
            cyc();
        end
        upd_valid = 1'b0;
        clear_req = 1'b0;
        repeat (20) cyc();

        // Reset asserted partway through a clear sweep.
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        repeat (7) cyc();
        rst_n = 1'b0;
        #2;
        chk("midclr ready16", int'(rdy[0]), 1);
        chk("midclr ready12", int'(rdy[1]), 1);
        chk("midclr rd16", int'(rdw[0]), 0);
        chk("midclr count16", int'(ucnt[0]), 0);
        chk("midclr flags12", int'({satf[1], ierr[1], done[1]}), 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        dn16 = 0; hi16 = 0;
        for (int c = 0; c < 30; c++) begin
            if (done[0] || done[1]) dn16++;
            if (rdy[0] && rdy[1]) hi16++;
            cyc();
        end
        chk("no done after reset", dn16, 0);
        chk("ready after reset", hi16, 30);
        check_all_init("midreset");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
`default_nettype wire
